// File: rtl/ahb_job_slave.sv
// AHB-Lite register slave that stages RC4 image jobs, queues them for the MCU,
// and tracks job completion/failure with a status word and a one-cycle irq.
module ahb_job_slave #(
  parameter int DEPTH   = 4,
  parameter int KEY_W   = 32,
  parameter int DIM_W   = 12,
  parameter int SADDR_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [SADDR_W-1:0] job_saddr,
  output logic [KEY_W-1:0]   job_key,
  output logic [DIM_W-1:0]   job_width,
  output logic [DIM_W-1:0]   job_height,
  input  logic               process_complete,
  input  logic               error,
  output logic               irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OFF_SADDR  = 3'd0;
  localparam logic [2:0] OFF_KEY    = 3'd1;
  localparam logic [2:0] OFF_WIDTH  = 3'd2;
  localparam logic [2:0] OFF_HEIGHT = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  typedef struct packed {
    logic [SADDR_W-1:0] saddr;
    logic [KEY_W-1:0]   key;
    logic [DIM_W-1:0]   width;
    logic [DIM_W-1:0]   height;
  } job_t;

  // The first ERROR cycle is combinational from the data phase; only the
  // second cycle needs remembering.
  typedef enum logic {ST_OK, ST_ERR2} state_e;

  state_e             state_q, state_d;
  logic               dphase_q, dwr_q;
  logic [2:0]         doff_q, dsize_q;
  logic [SADDR_W-1:0] saddr_q;
  logic [KEY_W-1:0]   key_q;
  logic [DIM_W-1:0]   width_q, height_q;
  job_t               mem_q [DEPTH];
  job_t               head;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, err_sticky_q, irq_q;
  logic [7:0]         done_cnt_q;

  logic bad, err_now, wr_ok, rd_ok, push, pop, clr, done, full;
  logic unused_ok;

  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign full    = (count_q == CNT_W'(DEPTH));
  assign err_now = dphase_q & bad;
  assign wr_ok   = dphase_q & dwr_q & ~bad;
  assign rd_ok   = dphase_q & ~dwr_q & ~bad;
  assign push    = wr_ok & (doff_q == OFF_CTRL) & HWDATA[0];
  assign clr     = wr_ok & (doff_q == OFF_CTRL) & HWDATA[1];
  assign pop     = job_valid & job_ready;
  assign done    = busy_q & (process_complete | error);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    bad = 1'b0;
    if (dsize_q != 3'b010)                                   bad = 1'b1;
    if (doff_q > OFF_STATUS)                                 bad = 1'b1;
    if (dwr_q && doff_q == OFF_STATUS)                       bad = 1'b1;
    if (dwr_q && doff_q == OFF_CTRL && HWDATA[0] && full)    bad = 1'b1;
  end

  always_comb begin
    state_d   = ST_OK;
    HREADYOUT = 1'b1;
    HRESP     = (state_q == ST_ERR2);
    if (err_now) begin
      HREADYOUT = 1'b0;
      HRESP     = 1'b1;
      state_d   = ST_ERR2;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_ok) begin
      case (doff_q)
        OFF_SADDR:  HRDATA = 32'(saddr_q);
        OFF_KEY:    HRDATA = 32'(key_q);
        OFF_WIDTH:  HRDATA = 32'(width_q);
        OFF_HEIGHT: HRDATA = 32'(height_q);
        OFF_STATUS: HRDATA = {8'd0, done_cnt_q, 8'(count_q), 6'd0, err_sticky_q, busy_q};
        default:    HRDATA = 32'd0;
      endcase
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign job_valid  = (count_q != '0) & ~busy_q;
  assign job_saddr  = head.saddr;
  assign job_key    = head.key;
  assign job_width  = head.width;
  assign job_height = head.height;
  assign irq        = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OK;
      dphase_q     <= 1'b0;
      dwr_q        <= 1'b0;
      doff_q       <= '0;
      dsize_q      <= '0;
      saddr_q      <= '0;
      key_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      // HREADY is low during the first ERROR cycle, so nothing is captured there.
      dphase_q <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        dwr_q   <= HWRITE;
        doff_q  <= HADDR[4:2];
        dsize_q <= HSIZE;
      end
      if (wr_ok) begin
        case (doff_q)
          OFF_SADDR:  saddr_q  <= HWDATA[SADDR_W-1:0];
          OFF_KEY:    key_q    <= HWDATA[KEY_W-1:0];
          OFF_WIDTH:  width_q  <= HWDATA[DIM_W-1:0];
          OFF_HEIGHT: height_q <= HWDATA[DIM_W-1:0];
          default: ;
        endcase
      end
      if (push) begin
        mem_q[wr_ptr_q] <= '{saddr: saddr_q, key: key_q, width: width_q, height: height_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (pop)       busy_q <= 1'b1;
      else if (done) busy_q <= 1'b0;
      if (busy_q & process_complete) done_cnt_q <= done_cnt_q + 8'd1;
      // A failure in the same cycle as a clear must not be lost.
      if (busy_q & error) err_sticky_q <= 1'b1;
      else if (clr)       err_sticky_q <= 1'b0;
      irq_q <= done;
    end
  end

endmodule
